siso_shift_sequencer: RTL

SISO_SHIFT_SEQUENCER -- requirements
Module: siso_shift_sequencer

---
 rtl/siso_shift_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/siso_shift_sequencer.sv
// Parallel-in/serial-out frame sequencer: IDLE -> SHIFT (FL bits) -> DONE -> IDLE, first bit one cycle after acceptance.
// Optional trailing even-parity bit when SISO_PARITY_EN is defined (FL = WIDTH+1); default build sends WIDTH data bits only.
module siso_shift_sequencer #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             Clk_In,
   input  logic             Reset_In,
   input  logic [WIDTH-1:0] Data_In,
   input  logic             Data_Valid_In,
   output logic             Data_Ready_Out,
   output logic             Serial_Data_Out,
   output logic             Shift_Enable_Out,
   output logic             Frame_Active_Out,
   output logic             Frame_Done_Out,
   output logic [5:0]       Bit_Count_Out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [5:0] LAST_DATA = 6'(WIDTH - 1);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic             r_serial, w_serial_nxt;
   logic [5:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic             w_last;

`ifdef SISO_PARITY_EN
   localparam logic [5:0] PAR_IDX = 6'(WIDTH);

   logic r_parity, w_parity_nxt;
   logic w_par_slot;

   assign w_last     = (r_bit_cnt == PAR_IDX);
   assign w_par_slot = (r_bit_cnt == LAST_DATA);
`else
   assign w_last = (r_bit_cnt == LAST_DATA);
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_serial_nxt     = 1'b0;
      w_bit_cnt_nxt    = 6'd0;
`ifdef SISO_PARITY_EN
      w_parity_nxt     = r_parity;
`endif
      Data_Ready_Out   = 1'b0;
      Shift_Enable_Out = 1'b0;
      Frame_Active_Out = 1'b0;
      Frame_Done_Out   = 1'b0;

      case (r_state)
         S_IDLE: begin
            Data_Ready_Out = 1'b1;
            if (Data_Valid_In) begin
               // The first bit is loaded straight into the output register so it shows next cycle.
               w_state_nxt = S_SHIFT;
               if (MSB_FIRST) begin
                  w_serial_nxt = Data_In[WIDTH-1];
                  w_shift_nxt  = {Data_In[WIDTH-2:0], 1'b0};
               end else begin
                  w_serial_nxt = Data_In[0];
                  w_shift_nxt  = {1'b0, Data_In[WIDTH-1:1]};
               end
`ifdef SISO_PARITY_EN
               w_parity_nxt = ^Data_In;
`endif
            end
         end

         S_SHIFT: begin
            Shift_Enable_Out = 1'b1;
            Frame_Active_Out = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
               w_shift_nxt = '0;
`ifdef SISO_PARITY_EN
            end else if (w_par_slot) begin
               w_serial_nxt  = r_parity;
               w_bit_cnt_nxt = r_bit_cnt + 6'd1;
`endif
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + 6'd1;
               if (MSB_FIRST) begin
                  w_serial_nxt = r_shift[WIDTH-1];
                  w_shift_nxt  = {r_shift[WIDTH-2:0], 1'b0};
               end else begin
                  w_serial_nxt = r_shift[0];
                  w_shift_nxt  = {1'b0, r_shift[WIDTH-1:1]};
               end
            end
         end

         S_DONE: begin
            Frame_Active_Out = 1'b1;
            Frame_Done_Out   = 1'b1;
            w_state_nxt      = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_serial  <= 1'b0;
         r_bit_cnt <= 6'd0;
`ifdef SISO_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_serial  <= w_serial_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
`ifdef SISO_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
      end
   end

   assign Serial_Data_Out = r_serial;
   assign Bit_Count_Out   = r_bit_cnt;

endmodule
